count_ctrl_arb: RTL and testbench

Command controller and two-port arbiter for the loadable up/down mod-(MAX_VAL+1) counter. It accepts LOAD/UP/DOWN/READ commands from two requesters over valid/ready and grants them round-robin. It sequences the counter's load/mode/enable controls cycle by cycle and returns the resulting count to the granted requester. It sits between the command sources and the counter, and is the only driver of the counter's control inputs.

---
 rtl/count_ctrl_arb.sv | 148 ++++++++++++++
 tb/tb_count_ctrl_arb.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl_arb.sv
// Round-robin command controller for a loadable up/down mod-(MAX_VAL+1) counter.
// Serialises LOAD/UP/DOWN/READ from two requesters into cycle-level counter controls.
module count_ctrl_arb #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MAX_VAL = 11
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_data,
   output logic             cnt_load,
   output logic             cnt_mode,
   output logic             cnt_en,
   output logic [WIDTH-1:0] cnt_data_in,
   input  logic [WIDTH-1:0] cnt_data_out,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_value,
   output logic             rsp_err,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StExec, StSettle, StResp} state_e;

   localparam logic [1:0]       OpLoad = 2'b00;
   localparam logic [1:0]       OpUp   = 2'b01;
   localparam logic [1:0]       OpDown = 2'b10;
   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

   state_e           state_q, state_d;
   logic             rr_q, rr_d;
   logic [1:0]       op_q, op_d;
   logic             id_q, id_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] steps_q, steps_d;
   logic [WIDTH-1:0] rsp_value_q, rsp_value_d;
   logic             rsp_err_q, rsp_err_d;
   logic [WIDTH-1:0] data_in_q, data_in_d;

   logic             gnt0, gnt1, hs;
   logic [1:0]       sel_op;
   logic [WIDTH-1:0] sel_data;

   // rr_q = 1 gives requester 1 priority when both are valid
   always_comb begin
      gnt0     = req0_valid && (!req1_valid || !rr_q);
      gnt1     = req1_valid && (!req0_valid || rr_q);
      hs       = (state_q == StIdle) && (gnt0 || gnt1);
      sel_op   = gnt1 ? req1_op : req0_op;
      sel_data = gnt1 ? req1_data : req0_data;
   end

   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      op_d        = op_q;
      id_d        = id_q;
      err_d       = err_q;
      steps_d     = steps_q;
      rsp_value_d = rsp_value_q;
      rsp_err_d   = rsp_err_q;
      data_in_d   = data_in_q;
      case (state_q)
         StIdle: begin
            if (hs) begin
               id_d    = gnt1;
               op_d    = sel_op;
               rr_d    = ~gnt1;
               steps_d = sel_data;
               err_d   = 1'b0;
               case (sel_op)
                  OpLoad: begin
                     if (sel_data > MaxVal) begin
                        err_d   = 1'b1;
                        state_d = StSettle;
                     end else begin
                        data_in_d = sel_data;
                        state_d   = StExec;
                     end
                  end
                  OpUp, OpDown: state_d = (sel_data != '0) ? StExec : StSettle;
                  default:      state_d = StSettle;
               endcase
            end
         end
         StExec: begin
            if (op_q == OpLoad) begin
               state_d = StSettle;
            end else begin
               steps_d = steps_q - WIDTH'(1);
               if (steps_q == WIDTH'(1)) state_d = StSettle;
            end
         end
         StSettle: begin
            rsp_value_d = cnt_data_out;
            rsp_err_d   = err_q;
            state_d     = StResp;
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= StIdle;
         rr_q        <= 1'b0;
         op_q        <= 2'b00;
         id_q        <= 1'b0;
         err_q       <= 1'b0;
         steps_q     <= '0;
         rsp_value_q <= '0;
         rsp_err_q   <= 1'b0;
         data_in_q   <= '0;
      end else begin
         state_q     <= state_d;
         rr_q        <= rr_d;
         op_q        <= op_d;
         id_q        <= id_d;
         err_q       <= err_d;
         steps_q     <= steps_d;
         rsp_value_q <= rsp_value_d;
         rsp_err_q   <= rsp_err_d;
         data_in_q   <= data_in_d;
      end
   end

   always_comb begin
      req0_ready  = (state_q == StIdle) && gnt0;
      req1_ready  = (state_q == StIdle) && gnt1;
      cnt_load    = (state_q == StExec) && (op_q == OpLoad);
      cnt_en      = (state_q == StExec) && ((op_q == OpUp) || (op_q == OpDown));
      cnt_mode    = (state_q == StExec) && (op_q == OpUp);
      cnt_data_in = data_in_q;
      rsp_valid   = (state_q == StResp);
      rsp_id      = id_q;
      rsp_value   = rsp_value_q;
      rsp_err     = rsp_err_q;
      busy        = (state_q != StIdle);
   end

endmodule

// File: tb/tb_count_ctrl_arb.sv
// Directed bench for count_ctrl_arb with a behavioural mod-12 counter attached.
module tb_count_ctrl_arb;

   localparam logic [1:0] LOAD = 2'b00;
   localparam logic [1:0] UP   = 2'b01;
   localparam logic [1:0] DOWN = 2'b10;
   localparam logic [1:0] READ = 2'b11;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [1:0] req0_op = 2'b00, req1_op = 2'b00;
   logic [3:0] req0_data = 4'd0, req1_data = 4'd0;
   logic       cnt_load, cnt_mode, cnt_en;
   logic [3:0] cnt_data_in;
   logic [3:0] cnt_model = 4'd0;
   logic       rsp_valid, rsp_id, rsp_err, busy;
   logic [3:0] rsp_value;

   int errors = 0;
   int checks = 0;

   int m_rsp_cyc, m_rsp_id, m_rsp_value, m_rsp_err;
   int m_load_cnt, m_load_first, m_load_data;
   int m_en_cnt, m_en_first, m_up_cnt, m_both, m_busy_lo, m_rdy;
   int hs_wait;

   always #5 clock = ~clock;

   // Counter without reset: keeps its value across controller resets
   always @(posedge clock) begin
      if (cnt_load) cnt_model <= cnt_data_in;
      else if (cnt_en) begin
         if (cnt_mode) cnt_model <= (cnt_model == 4'd11) ? 4'd0 : cnt_model + 4'd1;
         else          cnt_model <= (cnt_model == 4'd0) ? 4'd11 : cnt_model - 4'd1;
      end
   end

   count_ctrl_arb #(.WIDTH(4), .MAX_VAL(11)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_data    (req0_data),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_data    (req1_data),
      .cnt_load     (cnt_load),
      .cnt_mode     (cnt_mode),
      .cnt_en       (cnt_en),
      .cnt_data_in  (cnt_data_in),
      .cnt_data_out (cnt_model),
      .rsp_valid    (rsp_valid),
      .rsp_id       (rsp_id),
      .rsp_value    (rsp_value),
      .rsp_err      (rsp_err),
      .busy         (busy)
   );

   // Called 1 time unit after a rising edge; returns 1 unit after the handshake edge.
   task automatic send(input bit id, input logic [1:0] op, input logic [3:0] data);
      bit got;
      got = 1'b0;
      hs_wait = 0;
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_data = data;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_data = data;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clock);
         got = id ? req1_ready : req0_ready;
         @(posedge clock); #1;
         if (!got) hs_wait++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL handshake_timeout: req%0d never got ready, required ready within 20", id);
      end
   endtask

   // Records observations for cycles 1..response; cycle 0 is the handshake cycle.
   task automatic watch();
      bit done;
      done = 1'b0;
      m_rsp_cyc = -1; m_rsp_id = -1; m_rsp_value = -1; m_rsp_err = -1;
      m_load_cnt = 0; m_load_first = -1; m_load_data = -1;
      m_en_cnt = 0; m_en_first = -1; m_up_cnt = 0; m_both = 0; m_busy_lo = 0; m_rdy = 0;
      for (int c = 1; c <= 40 && !done; c++) begin
         @(negedge clock);
         if (cnt_load) begin
            m_load_cnt++;
            if (m_load_first < 0) m_load_first = c;
            m_load_data = int'(cnt_data_in);
         end
         if (cnt_en) begin
            m_en_cnt++;
            if (m_en_first < 0) m_en_first = c;
            if (cnt_mode) m_up_cnt++;
         end
         if (cnt_load && cnt_en) m_both++;
         if (!busy) m_busy_lo++;
         if (req0_ready || req1_ready) m_rdy++;
         if (rsp_valid) begin
            m_rsp_cyc = c; m_rsp_id = int'(rsp_id);
            m_rsp_value = int'(rsp_value); m_rsp_err = int'(rsp_err);
            done = 1'b1;
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic run(input bit id, input logic [1:0] op, input logic [3:0] data);
      send(id, op, data);
      watch();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      #2;
      checks++;
      if ({req0_ready, req1_ready, cnt_load, cnt_mode, cnt_en, rsp_valid, rsp_id, rsp_err, busy}
          !== 9'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b want 000000000",
                  {req0_ready, req1_ready, cnt_load, cnt_mode, cnt_en, rsp_valid, rsp_id,
                   rsp_err, busy});
      end
      checks++;
      if (rsp_value !== 4'd0) begin
         errors++; $display("FAIL reset_rsp_value: got %0d want 0", rsp_value);
      end
      checks++;
      if (cnt_data_in !== 4'd0) begin
         errors++; $display("FAIL reset_data_in: got %0d want 0", cnt_data_in);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_load();
      run(1'b0, LOAD, 4'd7);
      checks++;
      if (hs_wait !== 0) begin errors++; $display("FAIL load_hs_wait: got %0d want 0", hs_wait); end
      checks++;
      if (m_load_cnt !== 1 || m_load_first !== 1) begin
         errors++;
         $display("FAIL load_pulse: got count %0d at cycle %0d want 1 at 1", m_load_cnt,
                  m_load_first);
      end
      checks++;
      if (m_load_data !== 7) begin
         errors++; $display("FAIL load_data: got %0d want 7", m_load_data);
      end
      checks++;
      if (m_en_cnt !== 0) begin errors++; $display("FAIL load_no_en: got %0d want 0", m_en_cnt); end
      checks++;
      if (m_rsp_cyc !== 3) begin errors++; $display("FAIL load_lat: got %0d want 3", m_rsp_cyc); end
      checks++;
      if (m_rsp_id !== 0 || m_rsp_value !== 7 || m_rsp_err !== 0) begin
         errors++;
         $display("FAIL load_rsp: got id %0d val %0d err %0d want 0 7 0", m_rsp_id, m_rsp_value,
                  m_rsp_err);
      end
      checks++;
      if (m_busy_lo !== 0 || m_rdy !== 0) begin
         errors++;
         $display("FAIL load_busy: got busy-low %0d ready %0d want 0 0", m_busy_lo, m_rdy);
      end
   endtask

   task automatic test_up_wrap();
      run(1'b1, LOAD, 4'd9);
      run(1'b1, UP, 4'd5);
      checks++;
      if (m_en_cnt !== 5 || m_en_first !== 1) begin
         errors++;
         $display("FAIL up_en: got %0d from cycle %0d want 5 from 1", m_en_cnt, m_en_first);
      end
      checks++;
      if (m_up_cnt !== 5) begin errors++; $display("FAIL up_mode: got %0d want 5", m_up_cnt); end
      checks++;
      if (m_load_cnt !== 0 || m_both !== 0) begin
         errors++; $display("FAIL up_no_load: got %0d %0d want 0 0", m_load_cnt, m_both);
      end
      checks++;
      if (m_rsp_cyc !== 7) begin errors++; $display("FAIL up_lat: got %0d want 7", m_rsp_cyc); end
      checks++;
      if (m_rsp_id !== 1 || m_rsp_value !== 2 || m_rsp_err !== 0) begin
         errors++;
         $display("FAIL up_rsp: got id %0d val %0d err %0d want 1 2 0", m_rsp_id, m_rsp_value,
                  m_rsp_err);
      end
   endtask

   task automatic test_down_read();
      run(1'b0, LOAD, 4'd1);
      run(1'b0, DOWN, 4'd3);
      checks++;
      if (m_en_cnt !== 3 || m_up_cnt !== 0) begin
         errors++; $display("FAIL down_en: got en %0d up %0d want 3 0", m_en_cnt, m_up_cnt);
      end
      checks++;
      if (m_rsp_cyc !== 5) begin errors++; $display("FAIL down_lat: got %0d want 5", m_rsp_cyc); end
      checks++;
      if (m_rsp_value !== 10) begin
         errors++; $display("FAIL down_value: got %0d want 10", m_rsp_value);
      end
      run(1'b0, READ, 4'd5);
      checks++;
      if (m_rsp_cyc !== 2) begin errors++; $display("FAIL read_lat: got %0d want 2", m_rsp_cyc); end
      checks++;
      if (m_rsp_value !== 10 || m_rsp_err !== 0) begin
         errors++;
         $display("FAIL read_rsp: got val %0d err %0d want 10 0", m_rsp_value, m_rsp_err);
      end
      checks++;
      if (m_en_cnt !== 0 || m_load_cnt !== 0) begin
         errors++; $display("FAIL read_ctrl: got en %0d load %0d want 0 0", m_en_cnt, m_load_cnt);
      end
   endtask

   task automatic test_error();
      run(1'b1, LOAD, 4'd4);
      run(1'b1, LOAD, 4'd13);
      checks++;
      if (m_load_cnt !== 0) begin
         errors++; $display("FAIL err_no_load: got %0d want 0", m_load_cnt);
      end
      checks++;
      if (m_rsp_cyc !== 2) begin errors++; $display("FAIL err_lat: got %0d want 2", m_rsp_cyc); end
      checks++;
      if (m_rsp_id !== 1 || m_rsp_value !== 4 || m_rsp_err !== 1) begin
         errors++;
         $display("FAIL err_rsp: got id %0d val %0d err %0d want 1 4 1", m_rsp_id, m_rsp_value,
                  m_rsp_err);
      end
      run(1'b0, LOAD, 4'd11);
      checks++;
      if (m_load_cnt !== 1 || m_rsp_value !== 11 || m_rsp_err !== 0) begin
         errors++;
         $display("FAIL load_max: got load %0d val %0d err %0d want 1 11 0", m_load_cnt,
                  m_rsp_value, m_rsp_err);
      end
      run(1'b0, LOAD, 4'd4);
      run(1'b0, UP, 4'd0);
      checks++;
      if (m_rsp_cyc !== 2 || m_en_cnt !== 0) begin
         errors++;
         $display("FAIL up0_lat: got cycle %0d en %0d want 2 0", m_rsp_cyc, m_en_cnt);
      end
      checks++;
      if (m_rsp_value !== 4 || m_rsp_err !== 0) begin
         errors++;
         $display("FAIL up0_rsp: got val %0d err %0d want 4 0", m_rsp_value, m_rsp_err);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] gseq, rseq;
      int gn, rn, r0, r1;
      gseq = 4'b0; rseq = 4'b0; gn = 0; rn = 0; r0 = 0; r1 = 0;
      resetn = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      req0_op = READ; req0_data = 4'd0; req0_valid = 1'b1;
      req1_op = READ; req1_data = 4'd0; req1_valid = 1'b1;
      for (int c = 0; c < 40 && rn < 4; c++) begin
         @(negedge clock);
         if (req0_ready) begin
            if (gn < 4) gseq[gn] = 1'b0;
            gn++; r0++;
         end
         if (req1_ready) begin
            if (gn < 4) gseq[gn] = 1'b1;
            gn++; r1++;
         end
         if (rsp_valid) begin
            if (rn < 4) rseq[rn] = rsp_id;
            rn++;
         end
         @(posedge clock); #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (gn !== 4 || gseq !== 4'b1010) begin
         errors++; $display("FAIL rr_grants: got %0d grants seq %b want 4 seq 1010", gn, gseq);
      end
      checks++;
      if (rn !== 4 || rseq !== 4'b1010) begin
         errors++; $display("FAIL rr_rsp_id: got %0d rsps seq %b want 4 seq 1010", rn, rseq);
      end
      checks++;
      if (r0 !== 2 || r1 !== 2) begin
         errors++; $display("FAIL rr_ready_pulses: got %0d %0d want 2 2", r0, r1);
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      stray = 0;
      send(1'b0, UP, 4'd8);
      @(posedge clock); #1;
      @(posedge clock); #1;
      #1;
      checks++;
      if (cnt_en !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL mid_pre: got en %b busy %b want 1 1", cnt_en, busy);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({cnt_en, cnt_mode, busy, rsp_valid} !== 4'b0) begin
         errors++;
         $display("FAIL mid_async: got %b want 0000", {cnt_en, cnt_mode, busy, rsp_valid});
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (rsp_valid) stray++;
      end
      resetn = 1'b1;
      req0_op = READ; req0_data = 4'd0; req0_valid = 1'b1;
      req1_op = READ; req1_data = 4'd0; req1_valid = 1'b1;
      #1;
      checks++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_first_grant: got ready %b%b want 10", req0_ready, req1_ready);
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      watch();
      checks++;
      if (stray !== 0) begin errors++; $display("FAIL mid_no_rsp: got %0d want 0", stray); end
      checks++;
      if (m_rsp_id !== 0 || m_rsp_value !== 6) begin
         errors++;
         $display("FAIL mid_read: got id %0d val %0d want 0 6", m_rsp_id, m_rsp_value);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_up_wrap();
      test_down_read();
      test_error();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
